// File: rtl/ccastles_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ccastles_vram_arbiter
// Purpose  : Shares the single-port bitmap VRAM between scanout fetch (fixed
//            priority on pixel slots) and CPU req/ack accesses.
// Option   : CCASTLES_VRAM_BLANK_ONLY_EN restricts CPU grants to blanking.
// Revision : 1.0  initial release
// ============================================================================
module ccastles_vram_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic        hblank,
    input  logic        vblank,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,
    output logic [14:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    output logic [7:0]  pix_data,
    output logic        pix_valid
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;
    localparam logic [1:0] ST_ACK    = 2'd3;

    logic [1:0]  state_q,     state_d;
    logic        op_we_q,     op_we_d;
    logic [14:0] ram_addr_q,  ram_addr_d;
    logic [7:0]  ram_din_q,   ram_din_d;
    logic        ram_we_q,    ram_we_d;
    logic [7:0]  cpu_dout_q,  cpu_dout_d;
    logic        vid_issue_q, vid_issue_d;
    logic        vid_wait_q,  vid_wait_d;
    logic [7:0]  pix_data_q,  pix_data_d;
    logic        pix_valid_q, pix_valid_d;

    logic        w_video_slot;
    logic        w_cpu_window;
    logic        w_cpu_grant;
    logic        w_unused_vc;

    // Only 256 scanlines are addressable; the upper vertical bits are ignored.
    assign w_unused_vc = &{1'b0, vc[9:8]};

    assign w_video_slot = ce_pix && (hc[1:0] == 2'b00) && !hc[9] && !hblank && !vblank;

`ifdef CCASTLES_VRAM_BLANK_ONLY_EN
    assign w_cpu_window = hblank | vblank;
`else
    assign w_cpu_window = 1'b1;
`endif

    assign w_cpu_grant = !w_video_slot && cpu_req && w_cpu_window && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        op_we_d     = op_we_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_we_d    = 1'b0;
        cpu_dout_d  = cpu_dout_q;
        vid_issue_d = 1'b0;
        vid_wait_d  = vid_issue_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = 1'b0;

        if (w_video_slot) begin
            ram_addr_d  = {vc[7:0], hc[8:2]};
            vid_issue_d = 1'b1;
        end else if (w_cpu_grant) begin
            ram_addr_d = cpu_addr;
            ram_din_d  = cpu_din;
            ram_we_d   = cpu_we;
            op_we_d    = cpu_we;
        end

        // Video read data returns one cycle after the issue cycle.
        if (vid_wait_q) begin
            pix_data_d  = ram_dout;
            pix_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE:   if (w_cpu_grant) state_d = ST_ISSUE;
            ST_ISSUE:  state_d = op_we_q ? ST_ACK : ST_RDWAIT;
            ST_RDWAIT: begin
                cpu_dout_d = ram_dout;
                state_d    = ST_ACK;
            end
            ST_ACK:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_we_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_we_q    <= 1'b0;
            cpu_dout_q  <= '0;
            vid_issue_q <= 1'b0;
            vid_wait_q  <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_we_q     <= op_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_we_q    <= ram_we_d;
            cpu_dout_q  <= cpu_dout_d;
            vid_issue_q <= vid_issue_d;
            vid_wait_q  <= vid_wait_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign cpu_ack   = (state_q == ST_ACK);
    assign cpu_dout  = cpu_dout_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_we    = ram_we_q;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ccastles_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccastles_vram_arbiter
// Purpose  : Directed vector bench for ccastles_vram_arbiter with a VRAM model.
// Option   : CCASTLES_VRAM_BLANK_ONLY_EN selects the blank-only expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_ccastles_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_pix;
    logic        hblank;
    logic        vblank;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic [7:0]  cpu_dout;
    logic [14:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  pix_data;
    logic        pix_valid;

    logic [7:0]  mem [0:32767];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [7:0]  din;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    ccastles_vram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .ce_pix    (ce_pix),
        .hblank    (hblank),
        .vblank    (vblank),
        .hc        (hc),
        .vc        (vc),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_ack   (cpu_ack),
        .cpu_dout  (cpu_dout),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .pix_data  (pix_data),
        .pix_valid (pix_valid)
    );

    // Single-port RAM with one-cycle synchronous read.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        mem[15'h0282] = 8'hA3;
        mem[15'h0283] = 8'h3C;
        mem[15'h0284] = 8'h77;

        vecs[0] = '{we: 1'b1, addr: 15'h1234, din: 8'h5A, exp: 8'h00};
        vecs[1] = '{we: 1'b1, addr: 15'h0000, din: 8'h11, exp: 8'h00};
        vecs[2] = '{we: 1'b1, addr: 15'h7FFF, din: 8'hC3, exp: 8'h00};
        vecs[3] = '{we: 1'b0, addr: 15'h1234, din: 8'h00, exp: 8'h5A};
        vecs[4] = '{we: 1'b0, addr: 15'h7FFF, din: 8'hFF, exp: 8'hC3};
        vecs[5] = '{we: 1'b0, addr: 15'h0000, din: 8'h00, exp: 8'h11};
        vecs[6] = '{we: 1'b0, addr: 15'h0282, din: 8'h00, exp: 8'hA3};
        vecs[7] = '{we: 1'b1, addr: 15'h0000, din: 8'hE7, exp: 8'h00};

        reset = 1'b1; ce_pix = 1'b0; hblank = 1'b0; vblank = 1'b1;
        hc = 10'd0; vc = 10'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;

        // Reset state
        tick(); tick();
        chk("rst_ack",       {31'd0, cpu_ack},   32'd0);
        chk("rst_dout",      {24'd0, cpu_dout},  32'd0);
        chk("rst_ram_addr",  {17'd0, ram_addr},  32'd0);
        chk("rst_ram_din",   {24'd0, ram_din},   32'd0);
        chk("rst_ram_we",    {31'd0, ram_we},    32'd0);
        chk("rst_pix_data",  {24'd0, pix_data},  32'd0);
        chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        reset = 1'b0;
        tick();

        // Reset in the middle of a write abandons it
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0100; cpu_din = 8'h99;
        tick();
        chk("midrst_issue_we", {31'd0, ram_we}, 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_we",   {31'd0, ram_we},   32'd0);
        chk("midrst_addr", {17'd0, ram_addr}, 32'd0);
        chk("midrst_din",  {24'd0, ram_din},  32'd0);
        chk("midrst_ack",  {31'd0, cpu_ack},  32'd0);
        tick();
        chk("midrst_ack2", {31'd0, cpu_ack},  32'd0);
        cpu_req = 1'b0; reset = 1'b0;
        tick();
        chk("midrst_ack3", {31'd0, cpu_ack},  32'd0);
        tick();

        // Video fetch at vc=5, hc=8 -> {vc[7:0], hc[8:2]} = 0x0282
        vblank = 1'b0; hblank = 1'b0; hc = 10'd8; vc = 10'd5; ce_pix = 1'b1;
        tick();
        chk("vid_addr",   {17'd0, ram_addr},  32'h0282);
        chk("vid_we",     {31'd0, ram_we},    32'd0);
        ce_pix = 1'b0;
        tick();
        chk("vid_valid_i1", {31'd0, pix_valid}, 32'd0);
        tick();
        chk("vid_data",     {24'd0, pix_data},  32'hA3);
        chk("vid_valid_i2", {31'd0, pix_valid}, 32'd1);
        tick();
        chk("vid_valid_i3", {31'd0, pix_valid}, 32'd0);
        vblank = 1'b1;

        // Uncontended CPU transactions from the vector table
        for (int i = 0; i < 8; i++) begin
            cpu_we = vecs[i].we; cpu_addr = vecs[i].addr; cpu_din = vecs[i].din;
            cpu_req = 1'b1;
            tick();
            chk($sformatf("v%0d_addr", i), {17'd0, ram_addr}, {17'd0, vecs[i].addr});
            chk($sformatf("v%0d_we", i),   {31'd0, ram_we},   {31'd0, vecs[i].we});
            if (vecs[i].we) begin
                chk($sformatf("v%0d_din", i), {24'd0, ram_din}, {24'd0, vecs[i].din});
                tick();
                chk($sformatf("v%0d_ack", i),    {31'd0, cpu_ack}, 32'd1);
                chk($sformatf("v%0d_we_off", i), {31'd0, ram_we},  32'd0);
            end else begin
                tick();
                chk($sformatf("v%0d_ack_early", i), {31'd0, cpu_ack}, 32'd0);
                tick();
                chk($sformatf("v%0d_ack", i),  {31'd0, cpu_ack},  32'd1);
                chk($sformatf("v%0d_dout", i), {24'd0, cpu_dout}, {24'd0, vecs[i].exp});
            end
            cpu_req = 1'b0;
            tick();
            chk($sformatf("v%0d_ack_off", i), {31'd0, cpu_ack}, 32'd0);
        end

        // CPU read colliding with a video slot (vc=5, hc=12 -> 0x0283)
        vblank = 1'b0; hc = 10'd12; vc = 10'd5; ce_pix = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234;
        tick();
        chk("cont_vid_addr", {17'd0, ram_addr}, 32'h0283);
        chk("cont_ack0",     {31'd0, cpu_ack},  32'd0);
        ce_pix = 1'b0;
        tick();
        chk("cont_cpu_addr", {17'd0, ram_addr}, 32'h1234);
        chk("cont_cpu_we",   {31'd0, ram_we},   32'd0);
        tick();
        chk("cont_pix_valid", {31'd0, pix_valid}, 32'd1);
        chk("cont_pix_data",  {24'd0, pix_data},  32'h3C);
        chk("cont_ack1",      {31'd0, cpu_ack},   32'd0);
        tick();
        chk("cont_ack",  {31'd0, cpu_ack},  32'd1);
        chk("cont_dout", {24'd0, cpu_dout}, 32'h5A);
        cpu_req = 1'b0;
        tick();

        // Back-to-back reads with req held; a video slot lands during RDWAIT
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234;
        tick();
        chk("b2b_addr1", {17'd0, ram_addr}, 32'h1234);
        hc = 10'd16; ce_pix = 1'b1;
        tick();
        chk("b2b_vid_addr", {17'd0, ram_addr}, 32'h0284);
        ce_pix = 1'b0;
        tick();
        chk("b2b_ack1",  {31'd0, cpu_ack},  32'd1);
        chk("b2b_dout1", {24'd0, cpu_dout}, 32'h5A);
        cpu_addr = 15'h7FFF;
        tick();
        chk("b2b_gap_ack",   {31'd0, cpu_ack},   32'd0);
        chk("b2b_pix_valid", {31'd0, pix_valid}, 32'd1);
        chk("b2b_pix_data",  {24'd0, pix_data},  32'h77);
        chk("b2b_dout_hold", {24'd0, cpu_dout},  32'h5A);
        tick();
        chk("b2b_addr2", {17'd0, ram_addr}, 32'h7FFF);
        tick();
        chk("b2b_ack2_early", {31'd0, cpu_ack}, 32'd0);
        tick();
        chk("b2b_ack2",  {31'd0, cpu_ack},  32'd1);
        chk("b2b_dout2", {24'd0, cpu_dout}, 32'hC3);
        cpu_req = 1'b0;
        tick();
        chk("b2b_ack_off", {31'd0, cpu_ack}, 32'd0);

        // CPU write during active display, no video slot, at hc=100
        vblank = 1'b0; hblank = 1'b0; hc = 10'd100; ce_pix = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0400; cpu_din = 8'h42;
`ifdef CCASTLES_VRAM_BLANK_ONLY_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("blk_stall%0d_we", i),  {31'd0, ram_we},  32'd0);
            chk($sformatf("blk_stall%0d_ack", i), {31'd0, cpu_ack}, 32'd0);
        end
        hblank = 1'b1;
        tick();
`else
        tick();
`endif
        chk("act_wr_we",   {31'd0, ram_we},   32'd1);
        chk("act_wr_addr", {17'd0, ram_addr}, 32'h0400);
        chk("act_wr_din",  {24'd0, ram_din},  32'h42);
        tick();
        chk("act_wr_ack",  {31'd0, cpu_ack},  32'd1);
        chk("act_wr_we_off", {31'd0, ram_we}, 32'd0);
        cpu_req = 1'b0; hblank = 1'b0; vblank = 1'b1;
        tick();
        chk("act_wr_mem", {24'd0, mem[15'h0400]}, 32'h42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
